// File: rtl/axi_rd_arbiter.sv
// rtl/axi_rd_arbiter.sv - three-way AXI read arbiter (Icache, Dcache, uncached) with ID-based return routing
// Optional round-robin grant: define AXI_RD_RR_ARB_EN.
module axi_rd_arbiter #(
  parameter logic [3:0] ID_ICACHE = 4'd0,
  parameter logic [3:0] ID_DCACHE = 4'd1,
  parameter logic [3:0] ID_UNC    = 4'd2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        icache_rd_req,
  input  logic [2:0]  icache_rd_type,
  input  logic [31:0] icache_rd_addr,
  output logic        icache_rd_rdy,
  output logic        icache_ret_valid,
  output logic        icache_ret_last,
  output logic [31:0] icache_ret_data,
  input  logic        dcache_rd_req,
  input  logic [2:0]  dcache_rd_type,
  input  logic [31:0] dcache_rd_addr,
  output logic        dcache_rd_rdy,
  output logic        dcache_ret_valid,
  output logic        dcache_ret_last,
  output logic [31:0] dcache_ret_data,
  input  logic        unc_req,
  input  logic [1:0]  unc_size,
  input  logic [31:0] unc_addr,
  output logic        unc_addr_ok,
  output logic        unc_data_ok,
  output logic [31:0] unc_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  typedef enum logic {AR_IDLE, AR_SEND} state_t;
  state_t state, state_nxt;

  logic busy_i, busy_d, busy_u;
  logic elig_i, elig_d, elig_u;
  logic gnt_i, gnt_d, gnt_u, gnt_any;
  logic idle_ok;
  logic clr_i, clr_d, clr_u;

  logic [31:0] sel_addr;
  logic [3:0]  sel_id;
  logic [2:0]  sel_type;
  logic [7:0]  sel_len;
  logic [2:0]  sel_size;

  assign elig_i  = icache_rd_req & ~busy_i;
  assign elig_d  = dcache_rd_req & ~busy_d;
  assign elig_u  = unc_req & ~busy_u;
  assign idle_ok = (state == AR_IDLE) & ~reset;
  assign gnt_any = gnt_i | gnt_d | gnt_u;

`ifdef AXI_RD_RR_ARB_EN
  // 0 = Icache, 1 = Dcache, 2 = uncached; first source searched next time
  logic [1:0] rr_ptr;

  always_comb begin
    gnt_i = 1'b0;
    gnt_d = 1'b0;
    gnt_u = 1'b0;
    if (idle_ok) begin
      case (rr_ptr)
        2'd1: begin
          if (elig_d) gnt_d = 1'b1;
          else if (elig_u) gnt_u = 1'b1;
          else if (elig_i) gnt_i = 1'b1;
        end
        2'd2: begin
          if (elig_u) gnt_u = 1'b1;
          else if (elig_i) gnt_i = 1'b1;
          else if (elig_d) gnt_d = 1'b1;
        end
        default: begin
          if (elig_i) gnt_i = 1'b1;
          else if (elig_d) gnt_d = 1'b1;
          else if (elig_u) gnt_u = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) rr_ptr <= 2'd0;
    else if (gnt_i) rr_ptr <= 2'd1;
    else if (gnt_d) rr_ptr <= 2'd2;
    else if (gnt_u) rr_ptr <= 2'd0;
  end
`else
  always_comb begin
    gnt_i = 1'b0;
    gnt_d = 1'b0;
    gnt_u = 1'b0;
    if (idle_ok) begin
      if (elig_d) gnt_d = 1'b1;
      else if (elig_u) gnt_u = 1'b1;
      else if (elig_i) gnt_i = 1'b1;
    end
  end
`endif

  assign icache_rd_rdy = gnt_i;
  assign dcache_rd_rdy = gnt_d;
  assign unc_addr_ok   = gnt_u;

  always_comb begin
    sel_addr = icache_rd_addr;
    sel_id   = ID_ICACHE;
    sel_type = icache_rd_type;
    sel_len  = 8'd0;
    sel_size = 3'd2;
    if (gnt_d) begin
      sel_addr = dcache_rd_addr;
      sel_id   = ID_DCACHE;
      sel_type = dcache_rd_type;
    end
    if (gnt_u) begin
      sel_addr = unc_addr;
      sel_id   = ID_UNC;
      sel_size = {1'b0, unc_size};
    end else begin
      case (sel_type)
        3'b100: begin sel_len = 8'd3; sel_size = 3'd2; end
        3'b000, 3'b001, 3'b010: sel_size = sel_type;
        default: sel_size = 3'd2;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      AR_IDLE: if (gnt_any) state_nxt = AR_SEND;
      AR_SEND: if (arready) state_nxt = AR_IDLE;
      default: state_nxt = AR_IDLE;
    endcase
  end

  assign clr_i = rvalid & rlast & (rid == ID_ICACHE);
  assign clr_d = rvalid & rlast & (rid == ID_DCACHE);
  assign clr_u = rvalid & rlast & (rid == ID_UNC);

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= AR_IDLE;
      araddr <= 32'd0;
      arid   <= 4'd0;
      arlen  <= 8'd0;
      arsize <= 3'd2;
      busy_i <= 1'b0;
      busy_d <= 1'b0;
      busy_u <= 1'b0;
    end else begin
      state <= state_nxt;
      if (gnt_any) begin
        araddr <= sel_addr;
        arid   <= sel_id;
        arlen  <= sel_len;
        arsize <= sel_size;
      end
      busy_i <= (busy_i & ~clr_i) | gnt_i;
      busy_d <= (busy_d & ~clr_d) | gnt_d;
      busy_u <= (busy_u & ~clr_u) | gnt_u;
    end
  end

  assign arvalid = (state == AR_SEND);
  assign arburst = 2'b01;
  assign rready  = 1'b1;

  // Beats with an unknown rid match no source and simply vanish
  assign icache_ret_valid = rvalid & (rid == ID_ICACHE);
  assign icache_ret_last  = rvalid & rlast & (rid == ID_ICACHE);
  assign icache_ret_data  = rdata;
  assign dcache_ret_valid = rvalid & (rid == ID_DCACHE);
  assign dcache_ret_last  = rvalid & rlast & (rid == ID_DCACHE);
  assign dcache_ret_data  = rdata;
  assign unc_data_ok      = clr_u;
  assign unc_rdata        = rdata;

endmodule
